// File: rtl/seq4_pkg.sv
// Shared definitions for the seq4 digit sequencer: FSM state encodings,
// digit width and default sizing parameters.
package seq4_pkg;

  typedef enum logic [1:0] {
    ENTRY = 2'd0,
    PLAY  = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned DIGIT_W      = 4;
  localparam int unsigned DEPTH_DEF    = 6;
  localparam int unsigned TICK_DIV_DEF = 50000000;

endpackage

// File: rtl/seq4_edge_det.sv
// 1-bit rising-edge detector. The previous input value is registered and
// cleared by the synchronous reset, so an input held high through reset
// produces an event on the first cycle after reset.
module seq4_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic prev;

  // History register holding the input value from the previous cycle
  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= din;
  end

  assign rise = din & ~prev;

endmodule

// File: rtl/seq4_ctrl.sv
// Digit sequence controller: stores up to DEPTH 4-bit digits and plays them
// back one per TICK_DIV clock cycles. HEX decoding lives outside this block.
// Build option: define SEQ4_LOOP_EN to make playback repeat indefinitely
// instead of ending in DONE.
module seq4_ctrl
  import seq4_pkg::*;
#(
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
  input  logic                       CLOCK_50,
  input  logic                       RESET,
  input  logic                       load_req,
  input  logic                       play_req,
  input  logic                       clear_req,
  input  logic [DIGIT_W-1:0]         sw_data,
  output logic [DIGIT_W*DEPTH-1:0]   seq_digits,
  output logic [2:0]                 count,
  output logic [DIGIT_W-1:0]         play_digit,
  output logic                       play_valid,
  output logic                       full,
  output logic                       empty,
  output logic [1:0]                 state
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

  state_t               cur_state, nxt_state;
  logic [DIGIT_W-1:0]   slots [DEPTH];
  logic [2:0]           idx;
  logic [TW-1:0]        tick;
  logic [DIGIT_W-1:0]   last_digit;

  logic load_ev, play_ev, clear_ev;
  logic do_load, do_start, wrap, last_step;

  seq4_edge_det u_load_edge  (.clk(CLOCK_50), .rst(RESET), .din(load_req),  .rise(load_ev));
  seq4_edge_det u_play_edge  (.clk(CLOCK_50), .rst(RESET), .din(play_req),  .rise(play_ev));
  seq4_edge_det u_clear_edge (.clk(CLOCK_50), .rst(RESET), .din(clear_req), .rise(clear_ev));

  assign full       = (count == 3'(DEPTH));
  assign empty      = (count == 3'd0);
  assign wrap       = (tick == TICK_MAX);
  assign last_step  = (idx == count - 3'd1);
  assign play_valid = (cur_state == PLAY);
  assign state      = cur_state;

  // While playing the current slot is shown directly; otherwise the last
  // played digit is held (zero after reset or clear).
  assign play_digit = (cur_state == PLAY) ? slots[idx] : last_digit;

  // Flatten the slot array onto the output bus, slot k at bits [4k+3:4k]
  always_comb begin
    seq_digits = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      seq_digits[k*DIGIT_W +: DIGIT_W] = slots[k];
    end
  end

  // FSM state register
  always_ff @(posedge CLOCK_50) begin
    if (RESET) cur_state <= ENTRY;
    else       cur_state <= nxt_state;
  end

  // Next-state logic and datapath strobes; clear outranks load and play,
  // and in ENTRY a performed load outranks play
  always_comb begin
    nxt_state = cur_state;
    do_load   = 1'b0;
    do_start  = 1'b0;
    if (clear_ev) begin
      nxt_state = ENTRY;
    end else begin
      case (cur_state)
        ENTRY: begin
          if (load_ev && !full) begin
            do_load = 1'b1;
          end else if (play_ev && !empty) begin
            do_start  = 1'b1;
            nxt_state = PLAY;
          end
        end
        PLAY: begin
          if (play_ev) begin
            do_start = 1'b1;
          end else if (wrap && last_step) begin
`ifdef SEQ4_LOOP_EN
            nxt_state = PLAY;
`else
            nxt_state = DONE;
`endif
          end
        end
        DONE: begin
          if (play_ev) begin
            do_start  = 1'b1;
            nxt_state = PLAY;
          end
        end
        default: nxt_state = ENTRY;
      endcase
    end
  end

  // Slot storage, digit count, playback index and step timer
  always_ff @(posedge CLOCK_50) begin
    if (RESET || clear_ev) begin
      for (int unsigned k = 0; k < DEPTH; k++) slots[k] <= '0;
      count      <= '0;
      idx        <= '0;
      tick       <= '0;
      last_digit <= '0;
    end else begin
      if (cur_state == PLAY) last_digit <= slots[idx];
      if (do_load) begin
        slots[count] <= sw_data;
        count        <= count + 3'd1;
      end
      if (do_start) begin
        idx  <= '0;
        tick <= '0;
      end else if (cur_state == PLAY) begin
        if (wrap) begin
          tick <= '0;
          // final step returns idx to 0 whether leaving for DONE or looping
          idx  <= last_step ? 3'd0 : idx + 3'd1;
        end else begin
          tick <= tick + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq4_ctrl.sv
// Directed self-checking bench for seq4_ctrl with DEPTH=6, TICK_DIV=4.
// Honors SEQ4_LOOP_EN for the playback-end expectations.
module tb_seq4_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_req, play_req, clear_req;
  logic [3:0]  sw_data;
  logic [23:0] seq_digits;
  logic [2:0]  count;
  logic [3:0]  play_digit;
  logic        play_valid, full, empty;
  logic [1:0]  state;

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_seq [3];

  seq4_ctrl #(.DEPTH(6), .TICK_DIV(4)) dut (
    .CLOCK_50   (clk),
    .RESET      (rst),
    .load_req   (load_req),
    .play_req   (play_req),
    .clear_req  (clear_req),
    .sw_data    (sw_data),
    .seq_digits (seq_digits),
    .count      (count),
    .play_digit (play_digit),
    .play_valid (play_valid),
    .full       (full),
    .empty      (empty),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] d);
    sw_data  = d;
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    step();
  endtask

  task automatic play_pulse();
    play_req = 1'b1;
    step();
    play_req = 1'b0;
  endtask

  initial begin
    exp_seq[0] = 4'h3;
    exp_seq[1] = 4'hA;
    exp_seq[2] = 4'h7;
    rst = 1'b1; load_req = 1'b0; play_req = 1'b0; clear_req = 1'b0; sw_data = 4'h0;
    repeat (3) step();

    // reset state
    check("rst_state", 32'(state), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_seq",   32'(seq_digits), 32'd0);
    check("rst_pdig",  32'(play_digit), 32'd0);
    check("rst_valid", 32'(play_valid), 32'd0);
    check("rst_full",  32'(full), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    rst = 1'b0;
    step();

    // three loads
    load(4'h3); load(4'hA); load(4'h7);
    check("ld3_count", 32'(count), 32'd3);
    check("ld3_seq",   32'(seq_digits[11:0]), 32'h7A3);
    check("ld3_empty", 32'(empty), 32'd0);

    // playback: each digit held 4 cycles
    play_pulse();
    for (int i = 0; i < 12; i++) begin
      check("play_digit", 32'(play_digit), 32'(exp_seq[i/4]));
      check("play_valid", 32'(play_valid), 32'd1);
      step();
    end
`ifdef SEQ4_LOOP_EN
    check("loop_state", 32'(state), 32'd1);
    check("loop_digit", 32'(play_digit), 32'h3);
    check("loop_valid", 32'(play_valid), 32'd1);
`else
    check("done_state", 32'(state), 32'd2);
    check("done_valid", 32'(play_valid), 32'd0);
    check("done_digit", 32'(play_digit), 32'h7);
    // load in DONE ignored
    load(4'h9);
    check("done_ld_count", 32'(count), 32'd3);
    // play from DONE restarts at idx 0
    play_pulse();
    check("restart_state", 32'(state), 32'd1);
    check("restart_digit", 32'(play_digit), 32'h3);
`endif

    // restart while playing: advance to idx 1, then play again
    play_pulse();
    repeat (4) step();
    check("mid_digit_a", 32'(play_digit), 32'hA);
    play_pulse();
    check("replay_digit", 32'(play_digit), 32'h3);
    check("replay_state", 32'(state), 32'd1);

    // reset mid-PLAY at idx 1
    repeat (4) step();
    check("pre_rst_digit", 32'(play_digit), 32'hA);
    rst = 1'b1;
    step();
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_valid", 32'(play_valid), 32'd0);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_pdig",  32'(play_digit), 32'd0);
    rst = 1'b0;
    step();

    // fill: 7 loads, the 7th ignored
    for (int v = 1; v <= 7; v++) load(4'(v));
    check("full_count", 32'(count), 32'd6);
    check("full_flag",  32'(full), 32'd1);
    check("full_slot5", 32'(seq_digits[23:20]), 32'd6);
    check("full_seq",   32'(seq_digits), 32'h654321);

    // load, play, clear together while playing -> clear wins
    play_pulse();
    step();
    check("pre_clr_state", 32'(state), 32'd1);
    load_req = 1'b1; play_req = 1'b1; clear_req = 1'b1;
    step();
    check("clr_state", 32'(state), 32'd0);
    check("clr_count", 32'(count), 32'd0);
    check("clr_seq",   32'(seq_digits), 32'd0);
    check("clr_empty", 32'(empty), 32'd1);
    load_req = 1'b0; play_req = 1'b0; clear_req = 1'b0;
    step();

    // play while empty ignored
    play_pulse();
    step();
    check("empty_play_state", 32'(state), 32'd0);

    // load and play together in ENTRY: load wins
    sw_data = 4'h5; load_req = 1'b1; play_req = 1'b1;
    step();
    check("ldpl_count", 32'(count), 32'd1);
    check("ldpl_state", 32'(state), 32'd0);
    check("ldpl_slot0", 32'(seq_digits[3:0]), 32'h5);
    load_req = 1'b0; play_req = 1'b0;
    step();

    // input held high through reset yields one event after release
    sw_data = 4'hC; load_req = 1'b1; rst = 1'b1;
    repeat (2) step();
    check("held_rst_count", 32'(count), 32'd0);
    rst = 1'b0;
    step();
    check("held_ev_count", 32'(count), 32'd1);
    check("held_ev_slot0", 32'(seq_digits[3:0]), 32'hC);
    step();
    check("held_no_repeat", 32'(count), 32'd1);
    load_req = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq4_ctrl.md
SEQ4_CTRL -- requirements
Module: seq4_ctrl

Interface
REQ-001 Parameter DEPTH, default 6, sets the number of 4-bit sequence slots, one per HEX digit.
REQ-002 Parameter TICK_DIV, default 50000000, sets the number of CLOCK_50 cycles per playback step (1 s).
REQ-003 CLOCK_50  in  1  sole clock; all logic is on its rising edge.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 load_req  in  1  active-high level, already synchronized; each rising edge stores one digit.
REQ-006 play_req  in  1  active-high level; each rising edge starts playback.
REQ-007 clear_req  in  1  active-high level; each rising edge empties the sequence.
REQ-008 sw_data  in  4  digit value to store.
REQ-009 seq_digits  out  4*DEPTH  stored digits; slot k occupies bits [4k+3:4k].
REQ-010 count  out  3  number of stored digits, 0..DEPTH.
REQ-011 play_digit  out  4  digit currently being played.
REQ-012 play_valid  out  1  high while in PLAY.
REQ-013 full  out  1  high when count==DEPTH.
REQ-014 empty  out  1  high when count==0.
REQ-015 state  out  2  FSM state encoding: ENTRY=0, PLAY=1, DONE=2.

Function
REQ-016 Request inputs shall be rising-edge detected against their value in the previous cycle; only a 0->1 transition is an event.
REQ-017 ENTRY + load event + !full: the block shall write sw_data to slot count and increment count; both are visible the next cycle.
REQ-018 A load event while full, in PLAY, or in DONE shall be ignored with no state change.
REQ-019 ENTRY + play event + !empty: the block shall go to PLAY with idx=0 and the tick counter at 0.
REQ-020 A play event in ENTRY while empty shall be ignored.
REQ-021 If load and play events occur in the same ENTRY cycle, the load shall be performed and the play ignored.
REQ-022 In PLAY: play_digit=slot[idx] and play_valid=1.
REQ-023 In PLAY, the tick counter shall count 0..TICK_DIV-1 and wrap; on wrap, idx increments.
REQ-024 In PLAY, on wrap with idx==count-1, the block shall go to DONE, with idx and the tick counter cleared.
REQ-025 In DONE: play_valid=0 and play_digit holds the last played digit; a play event restarts PLAY from idx 0.
REQ-026 A play event while already in PLAY shall restart playback at idx 0 with the tick counter at 0.
REQ-027 A clear event in any state shall zero all slots, count, idx and the tick counter, and enter ENTRY.
REQ-028 A clear event shall take priority over load and play events in the same cycle.
REQ-029 idx width shall be 3 bits; the tick counter shall be $clog2(TICK_DIV) bits; idx shall never exceed count-1.

Reset
REQ-030 RESET shall act on the next rising CLOCK_50 edge and override all events.
REQ-031 On reset, state shall be ENTRY.
REQ-032 On reset: seq_digits=0, count=0, play_digit=0, play_valid=0, full=0, empty=1.
REQ-033 On reset, edge-detect history shall be 0, so an input held high through reset produces an event on the first cycle after reset.
REQ-034 Reset during PLAY shall abort playback with no residual output.

Configuration
REQ-035 Macro SEQ4_LOOP_EN defined: on the final-step wrap, PLAY shall return to idx 0 and stay in PLAY; DONE is unreachable.
REQ-036 SEQ4_LOOP_EN undefined: behaviour is exactly per REQ-024/REQ-025.

Structure
REQ-037 Shared package seq4_pkg shall hold the state encodings, the digit width (4) and the DEPTH/TICK_DIV defaults.
REQ-038 Sub-module seq4_edge_det (1-bit registered rising-edge detector with synchronous reset) shall be instantiated once per request input.
REQ-039 The slot array and FSM shall reside in seq4_ctrl; HEX decoding shall stay outside this block.

Verification (TICK_DIV=4, DEPTH=6)
REQ-040 Reset, then load 0x3, 0xA, 0x7 -> count=3, seq_digits[11:0]=0x7A3, empty=0.
REQ-041 Load 7 times with values 1..7 -> count=6, full=1, the 7th load is ignored, slot5=6.
REQ-042 With 3 digits, play -> play_digit = 3, A, 7, each held 4 cycles, then state=DONE and play_valid=0 (macro off); with the macro on, the sequence repeats 3, A, 7, 3.
REQ-043 Load, play and clear rising in the same cycle -> ENTRY, count=0, seq_digits=0.
REQ-044 Play with count=0 -> state stays ENTRY; load and play rising together in ENTRY -> count+1, state ENTRY.
REQ-045 RESET asserted mid-PLAY at idx=1 -> next cycle state=ENTRY, play_valid=0, count=0.
